mem_bus_arbiter: RTL and testbench

Shares the single-port, variable-latency memory bus between the F-stage instruction fetch and the M-stage data access of the pipelined MIPS core. Grants one transaction at a time and gives the data side priority, with a bounded-starvation guarantee for fetch. Discards fetch responses made stale by a PC redirect (exception, eret, taken branch). Produces the busy signals that the hazard logic folds into PauseF and the M-stage stall.

---
 rtl/mem_bus_arbiter_pkg.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the F/M-stage memory bus arbiter.
//   arb_state_e : arbiter state encoding (IDLE=0, DM_ACC=1, IF_ACC=2, IF_DROP=3)
//   IF_BE       : byte enables driven for every instruction fetch
//   run_t       : width of the data-side fairness counter
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DM_ACC  = 2'd1,
    IF_ACC  = 2'd2,
    IF_DROP = 2'd3
  } arb_state_e;

  localparam logic [3:0] IF_BE = 4'hF;

  localparam int DM_RUN_W = 4;
  typedef logic [DM_RUN_W-1:0] run_t;

  // Saturating increment of the consecutive-DM-grant counter.
  function automatic run_t run_sat_inc(input run_t r, input run_t lim);
    return (r >= lim) ? lim : run_t'(r + 1'b1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter between instruction fetch (IF) and data
// memory (DM). One transaction in flight at a time; DM wins ties unless a
// waiting fetch has already been passed over MAX_DM_RUN times in a row.
// A redirect (if_flush) discards the pending or in-flight fetch; an
// in-flight bus cycle is still run to completion and its data dropped.
//
// Ports
//   Clk, Reset              clock, async active-low reset
//   if_req/if_addr/if_flush fetch request, address, redirect pulse
//   if_rdata/if_valid       fetched word and one-cycle completion pulse
//   if_busy                 fetch stall request (comb)
//   dm_req/we/be/addr/wdata data request, held until dm_done
//   dm_rdata/dm_done        load data (0 for stores) and completion pulse
//   dm_busy                 M-stage stall request (comb)
//   mem_req/we/be/addr/wdata bus request, fields registered at grant
//   mem_ready/mem_rdata     bus completion and read data
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MAX_DM_RUN = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_busy,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_done,
  output logic              dm_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam run_t RUN_MAX = run_t'(MAX_DM_RUN);

  arb_state_e        state_q, state_d;
  run_t              dm_run_q, dm_run_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              dm_done_q, dm_done_d;

  logic dm_elig, if_elig, grant_dm, grant_if;

  // A requester whose completion pulse is high this cycle is still holding
  // the request for the transaction that just finished; don't re-grant it.
  assign dm_elig = dm_req & ~dm_done_q;
  assign if_elig = if_req & ~if_valid_q;

  // DM has priority unless the waiting fetch has hit its starvation bound.
  assign grant_dm = (state_q == IDLE) & dm_elig & ~(if_elig & (dm_run_q == RUN_MAX));
  assign grant_if = (state_q == IDLE) & ~grant_dm & if_elig & ~if_flush;

  always_comb begin
    state_d    = state_q;
    dm_run_d   = dm_run_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    if_valid_d = 1'b0;
    dm_rdata_d = dm_rdata_q;
    dm_done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d  = DM_ACC;
          addr_d   = dm_addr;
          we_d     = dm_we;
          be_d     = dm_be;
          wdata_d  = dm_wdata;
          // Only count DM wins that actually made a fetch wait.
          dm_run_d = if_elig ? run_sat_inc(dm_run_q, RUN_MAX) : '0;
        end else if (grant_if) begin
          state_d  = IF_ACC;
          addr_d   = if_addr;
          we_d     = 1'b0;
          be_d     = IF_BE;
          wdata_d  = '0;
          dm_run_d = '0;
        end
      end
      DM_ACC: begin
        if (mem_ready) begin
          state_d    = IDLE;
          dm_done_d  = 1'b1;
          dm_rdata_d = we_q ? 32'h0 : mem_rdata;
        end
      end
      IF_ACC: begin
        if (mem_ready) begin
          state_d = IDLE;
          // A redirect coinciding with completion makes the word stale.
          if (!if_flush) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (if_flush) begin
          state_d = IF_DROP;
        end
      end
      IF_DROP: begin
        // Bus cycles cannot be aborted: hold the request, drop the data.
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      dm_run_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_rdata_q <= '0;
      dm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dm_run_q   <= dm_run_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      if_valid_q <= if_valid_d;
      dm_rdata_q <= dm_rdata_d;
      dm_done_q  <= dm_done_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_done   = dm_done_q;

  // Stall requests are combinational for the hazard unit; forced low while
  // in reset so every output is quiet during reset.
  assign if_busy = Reset & ((if_req & ~if_valid_q) | (state_q == IF_DROP));
  assign dm_busy = Reset & dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int AW   = 32;
  localparam int MAXR = 2;
  localparam int TMO  = 300;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          if_req, if_flush, if_valid, if_busy;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          dm_req, dm_we, dm_done, dm_busy;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata, dm_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  mem_bus_arbiter #(.ADDR_W(AW), .MAX_DM_RUN(MAXR)) dut (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_busy(if_busy),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_busy(dm_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q_if[$];
  logic [31:0] q_dm[$];
  bit          agents_on = 1'b0;
  bit          issue_en  = 1'b0;
  int          fixed_wait = 0;  // >= 0: fixed wait states; -1: random

  // Bus memory contents: reads return a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Bus responder: random (or fixed) wait states, then one-cycle ready.
  initial begin
    int wl;
    wl = -1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge Clk);
      mem_rdata = $urandom;
      if (!mem_req) begin
        mem_ready = 1'b0;
        wl = -1;
      end else begin
        if (wl < 0) wl = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        if (wl == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wl = -1;
        end else begin
          mem_ready = 1'b0;
          wl--;
        end
      end
    end
  end

  // Fetch agent: random fetches, random redirects, sometimes back-to-back.
  initial begin
    int age;
    age = 0;
    forever begin
      @(negedge Clk);
      if (agents_on) begin
        if_flush = 1'b0;
        if (if_req && if_valid) begin
          age = 0;
          if (issue_en && $urandom_range(0, 1) == 0) begin
            if_addr = AW'($urandom_range(0, 1023)) << 2;
            q_if.push_back(mem_word(if_addr));
          end else begin
            if_req = 1'b0;
          end
        end else if (if_req) begin
          age++;
          if (issue_en && $urandom_range(0, 14) == 0) begin
            if_flush = 1'b1;
            if_req   = 1'b0;
            void'(q_if.pop_back());
            age = 0;
          end else if (age > TMO) begin
            fail_now("if_wait");
            finish_now();
          end
        end else if (issue_en && $urandom_range(0, 1) == 0) begin
          if_addr = AW'($urandom_range(0, 1023)) << 2;
          if_req  = 1'b1;
          q_if.push_back(mem_word(if_addr));
        end
      end
    end
  end

  // Data agent: random loads/stores, often back-to-back.
  initial begin
    int age;
    bit nxt;
    age = 0;
    forever begin
      @(negedge Clk);
      if (agents_on) begin
        nxt = 1'b0;
        if (dm_req && dm_done) begin
          age = 0;
          dm_req = 1'b0;
          nxt = issue_en && ($urandom_range(0, 2) != 0);
        end else if (dm_req) begin
          age++;
          if (age > TMO) begin
            fail_now("dm_wait");
            finish_now();
          end
        end else begin
          nxt = issue_en && ($urandom_range(0, 2) != 0);
        end
        if (nxt) begin
          dm_we    = 1'($urandom_range(0, 1));
          dm_be    = 4'($urandom_range(1, 15));
          dm_addr  = AW'($urandom_range(0, 1023)) << 2;
          dm_wdata = $urandom;
          dm_req   = 1'b1;
          q_dm.push_back(dm_we ? 32'h0 : mem_word(dm_addr));
        end
      end
    end
  end

  // Scoreboard monitor: every completion must match the oldest expectation.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (Reset && if_valid) begin
        if (q_if.size() == 0) fail_now("if_valid_unexpected");
        else chk("if_rdata", if_rdata, q_if.pop_front());
      end
      if (Reset && dm_done) begin
        if (q_dm.size() == 0) fail_now("dm_done_unexpected");
        else chk("dm_rdata", dm_rdata, q_dm.pop_front());
      end
    end
  end

  // Bus-ownership model: who owns the bus each cycle, who should win the
  // next grant, and what the pulses and stall outputs must be.
  // owner: 0 none, 1 data, 2 fetch, 3 discarded fetch.
  initial begin
    int owner, run, g;
    bit exp_ifv, exp_dmd, dm_e, if_e;
    logic [AW-1:0] g_addr;
    logic g_we;
    logic [3:0] g_be;
    logic [31:0] g_wd;
    owner = 0; run = 0; g = 0; exp_ifv = 0; exp_dmd = 0;
    g_addr = '0; g_we = 0; g_be = '0; g_wd = '0;
    forever begin
      @(negedge Clk);
      #1;
      if (!Reset) begin
        owner = 0; run = 0; exp_ifv = 0; exp_dmd = 0;
      end else begin
        chk("mem_req", 32'(mem_req), 32'(owner != 0));
        if (owner != 0) begin
          chk("mem_addr", mem_addr, g_addr);
          chk("mem_we", 32'(mem_we), 32'(g_we));
          chk("mem_be", 32'(mem_be), 32'(g_be));
          if (g_we) chk("mem_wdata", mem_wdata, g_wd);
        end
        chk("if_valid", 32'(if_valid), 32'(exp_ifv));
        chk("dm_done", 32'(dm_done), 32'(exp_dmd));
        chk("if_busy", 32'(if_busy), 32'((if_req && !if_valid) || owner == 3));
        chk("dm_busy", 32'(dm_busy), 32'(dm_req && !dm_done));

        exp_ifv = (owner == 2) && mem_ready && !if_flush;
        exp_dmd = (owner == 1) && mem_ready;
        if (owner == 0) begin
          dm_e = dm_req && !dm_done;
          if_e = if_req && !if_valid;
          if (dm_e && !(if_e && run == MAXR)) begin
            g = 1;
            run = if_e ? ((run < MAXR) ? run + 1 : run) : 0;
            g_addr = dm_addr; g_we = dm_we; g_be = dm_be; g_wd = dm_wdata;
          end else if (if_e && !if_flush) begin
            g = 2;
            run = 0;
            g_addr = if_addr; g_we = 1'b0; g_be = 4'hF; g_wd = '0;
          end else begin
            g = 0;
          end
          owner = g;
        end else if (mem_ready) begin
          owner = 0;
        end else if (owner == 2 && if_flush) begin
          owner = 3;
        end
      end
    end
  end

  initial begin
    #2000000;
    fail_now("global_watchdog");
    finish_now();
  end

  initial begin
    bit seen;
    Reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h200; dm_wdata = 32'h1234;
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_dm_done", 32'(dm_done), 32'h0);
    chk("rst_if_busy", 32'(if_busy), 32'h0);
    chk("rst_dm_busy", 32'(dm_busy), 32'h0);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    fixed_wait = 0;

    // Lone fetch, zero wait states.
    @(negedge Clk);
    if_addr = 32'h3000; if_req = 1'b1;
    q_if.push_back(mem_word(32'h3000));
    @(negedge Clk); #1;
    chk("lone_mem_req", 32'(mem_req), 32'h1);
    chk("lone_mem_addr", mem_addr, 32'h3000);
    chk("lone_valid_c1", 32'(if_valid), 32'h0);
    @(negedge Clk); #1;
    chk("lone_valid_c2", 32'(if_valid), 32'h1);
    chk("lone_rdata", if_rdata, mem_word(32'h3000));
    @(negedge Clk);
    if_req = 1'b0;
    #1;
    chk("lone_valid_c3", 32'(if_valid), 32'h0);
    chk("lone_no_regrant", 32'(mem_req), 32'h0);

    // Simultaneous store and fetch: data first, fetch right after.
    @(negedge Clk);
    dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h10; dm_wdata = 32'hCAFEF00D; dm_req = 1'b1;
    if_addr = 32'h3004; if_req = 1'b1;
    q_dm.push_back(32'h0);
    q_if.push_back(mem_word(32'h3004));
    @(negedge Clk); #1;
    chk("sim_dm_we", 32'(mem_we), 32'h1);
    chk("sim_dm_be", 32'(mem_be), 32'h3);
    chk("sim_dm_addr", mem_addr, 32'h10);
    chk("sim_if_busy_c1", 32'(if_busy), 32'h1);
    @(negedge Clk); #1;
    chk("sim_dm_done", 32'(dm_done), 32'h1);
    chk("sim_if_busy_c2", 32'(if_busy), 32'h1);
    @(negedge Clk);
    dm_req = 1'b0;
    #1;
    chk("sim_if_we", 32'(mem_we), 32'h0);
    chk("sim_if_be", 32'(mem_be), 32'hF);
    chk("sim_if_addr", mem_addr, 32'h3004);
    chk("sim_if_busy_c3", 32'(if_busy), 32'h1);
    @(negedge Clk); #1;
    chk("sim_if_valid", 32'(if_valid), 32'h1);
    @(negedge Clk);
    if_req = 1'b0;

    // Randomized traffic.
    fixed_wait = -1;
    agents_on = 1'b1;
    issue_en = 1'b1;
    repeat (4000) @(negedge Clk);
    issue_en = 1'b0;
    for (int i = 0; i < TMO && (if_req || dm_req); i++) @(negedge Clk);
    if (if_req || dm_req) fail_now("drain");
    repeat (20) @(negedge Clk);
    agents_on = 1'b0;
    chk("if_queue_empty", 32'(q_if.size()), 32'h0);
    chk("dm_queue_empty", 32'(q_dm.size()), 32'h0);

    // Reset in the middle of a data access.
    fixed_wait = 5;
    @(negedge Clk);
    if_flush = 1'b0;
    dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h40; dm_req = 1'b1;
    q_dm.push_back(mem_word(32'h40));
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mid_dm_busy", 32'(dm_busy), 32'h0);
    repeat (2) begin
      @(negedge Clk); #1;
      chk("rst_mid_no_done", 32'(dm_done), 32'h0);
    end
    @(negedge Clk);
    Reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge Clk); #1;
      seen = dm_done;
    end
    chk("rst_regrant_done", 32'(seen), 32'h1);
    @(negedge Clk);
    dm_req = 1'b0;
    repeat (3) @(negedge Clk);
    chk("dm_queue_final", 32'(q_dm.size()), 32'h0);
    finish_now();
  end

endmodule
